// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bundle: hazard sources, memory handshake and control outputs.
// Latency: n/a (signal container only).
// Backpressure: n/a; freeze/bubble/flush outputs are the pipeline's stall controls.
interface pipeline_ctrl_if;
   logic        id_valid;
   logic [3:0]  id_src1;
   logic [3:0]  id_src2;
   logic        id_two_src;
   logic        exe_wb_en;
   logic        exe_mem_r_en;
   logic [3:0]  exe_dest;
   logic        mem_wb_en;
   logic [3:0]  mem_dest;
   logic        fwd_en;
   logic        branch_taken;
   logic        mem_req;
   logic        mem_ready;
   logic        freeze_if;
   logic        bubble_id;
   logic        flush;
   logic        freeze_all;
   logic        mem_busy;
   logic        mem_timeout;
   logic [15:0] stall_count;
   logic [15:0] flush_count;

   // Drives the pipeline status, observes the control decisions
   modport master (
      output id_valid, id_src1, id_src2, id_two_src,
      output exe_wb_en, exe_mem_r_en, exe_dest, mem_wb_en, mem_dest,
      output fwd_en, branch_taken, mem_req, mem_ready,
      input  freeze_if, bubble_id, flush, freeze_all, mem_busy,
      input  mem_timeout, stall_count, flush_count
   );

   // The controller itself
   modport slave (
      input  id_valid, id_src1, id_src2, id_two_src,
      input  exe_wb_en, exe_mem_r_en, exe_dest, mem_wb_en, mem_dest,
      input  fwd_en, branch_taken, mem_req, mem_ready,
      output freeze_if, bubble_id, flush, freeze_all, mem_busy,
      output mem_timeout, stall_count, flush_count
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/flush/memory-freeze controller with stall and flush statistics.
// Latency: control outputs are combinational (zero cycles); counters update on the edge.
// Backpressure: memory not ready freezes everything; flush beats hazard; hazard stalls IF/ID.
module pipeline_ctrl (
   input  logic           clk,
   input  logic           rst,
   pipeline_ctrl_if.slave bus
);

   typedef enum logic [0:0] {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_wait_cnt;
   logic        r_timeout;
   logic [15:0] r_stall_cnt;
   logic [15:0] r_flush_cnt;

   logic        w_freeze_all;
   logic        w_mem_busy;
   logic        w_flush;
   logic        w_freeze_if;
   logic        w_bubble_id;
   logic        w_hazard;
   logic        w_exe_hit;
   logic        w_mem_hit;
   logic        w_load_use;
   logic        w_wait_entry;
   logic        w_wait_tick;

   // Register-match terms: a source hits when it equals a destination being written
   always_comb begin
      w_exe_hit  = bus.exe_wb_en && ((bus.exe_dest == bus.id_src1) ||
                   (bus.id_two_src && (bus.exe_dest == bus.id_src2)));
      w_mem_hit  = bus.mem_wb_en && ((bus.mem_dest == bus.id_src1) ||
                   (bus.id_two_src && (bus.mem_dest == bus.id_src2)));
      // With forwarding only a load in EXE cannot be bypassed in time
      w_load_use = bus.exe_mem_r_en && w_exe_hit;
      w_hazard   = bus.id_valid && (bus.fwd_en ? w_load_use : (w_exe_hit || w_mem_hit));
   end

   // Next state and control outputs; reset forces every control low
   always_comb begin
      w_state_nxt  = r_state;
      w_freeze_all = 1'b0;
      w_mem_busy   = 1'b0;
      w_flush      = 1'b0;
      w_freeze_if  = 1'b0;
      w_bubble_id  = 1'b0;
      case (r_state)
         RUN: begin
            if (bus.mem_req && !bus.mem_ready) begin
               w_freeze_all = 1'b1;
               w_state_nxt  = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            if (bus.mem_ready) begin
               w_state_nxt = RUN;
            end else begin
               w_freeze_all = 1'b1;
               w_mem_busy   = 1'b1;
            end
         end
         default: w_state_nxt = RUN;
      endcase
      // Priority: freeze over branch flush over data hazard
      if (!w_freeze_all) begin
         if (bus.branch_taken) begin
            w_flush = 1'b1;
         end else if (w_hazard) begin
            w_freeze_if = 1'b1;
            w_bubble_id = 1'b1;
         end
      end
      if (!rst) begin
         w_state_nxt  = RUN;
         w_freeze_all = 1'b0;
         w_mem_busy   = 1'b0;
         w_flush      = 1'b0;
         w_freeze_if  = 1'b0;
         w_bubble_id  = 1'b0;
      end
   end

   assign w_wait_entry = (r_state == RUN) && (w_state_nxt == MEM_WAIT);
   assign w_wait_tick  = (r_state == MEM_WAIT) && !bus.mem_ready;

   // State register
   always_ff @(posedge clk) begin
      if (!rst) r_state <= RUN;
      else      r_state <= w_state_nxt;
   end

   // Wait counter and sticky timeout; the FSM keeps waiting after a timeout
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wait_cnt <= 8'd0;
         r_timeout  <= 1'b0;
      end else begin
         if (w_wait_entry) begin
            r_wait_cnt <= 8'd0;
         end else if (w_wait_tick && (r_wait_cnt != 8'hFF)) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
         end
         if (w_wait_tick && (r_wait_cnt == 8'hFE)) begin
            r_timeout <= 1'b1;
         end
      end
   end

   // Saturating statistics counters
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_stall_cnt <= 16'd0;
         r_flush_cnt <= 16'd0;
      end else begin
         if ((w_freeze_all || w_freeze_if) && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
         if (w_flush && (r_flush_cnt != 16'hFFFF)) begin
            r_flush_cnt <= r_flush_cnt + 16'd1;
         end
      end
   end

   assign bus.freeze_if   = w_freeze_if;
   assign bus.bubble_id   = w_bubble_id;
   assign bus.flush       = w_flush;
   assign bus.freeze_all  = w_freeze_all;
   assign bus.mem_busy    = w_mem_busy;
   assign bus.mem_timeout = r_timeout;
   assign bus.stall_count = r_stall_cnt;
   assign bus.flush_count = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios then random traffic.
// Expected outputs are queued per cycle and compared by an independent monitor.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_pipeline_ctrl;

   logic clk;
   logic rst;

   pipeline_ctrl_if bus ();

   pipeline_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      bit       rst;
      bit       id_valid;
      bit [3:0] s1;
      bit [3:0] s2;
      bit       two;
      bit       ewb;
      bit       emr;
      bit [3:0] ed;
      bit       mwb;
      bit [3:0] md;
      bit       fwd;
      bit       br;
      bit       req;
      bit       rdy;
   } stim_t;

   typedef struct {
      logic [4:0]  ctl;   // {freeze_if, bubble_id, flush, freeze_all, mem_busy}
      logic        tmo;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Reference model state, in plain terms
   bit waiting;      // a memory access is outstanding
   int waited;       // cycles spent waiting with memory not ready (capped at 255)
   bit timed_out;
   int stalls;
   int flushes;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
      end
   endtask

   // Does instruction in ID depend on a pending write, per the rule text?
   function automatic bit hazard_of(input stim_t s);
      bit uses_exe;
      bit uses_mem;
      uses_exe = s.ewb && (s.ed == s.s1 || (s.two && s.ed == s.s2));
      uses_mem = s.mwb && (s.md == s.s1 || (s.two && s.md == s.s2));
      if (!s.id_valid) return 1'b0;
      if (s.fwd)       return s.emr && uses_exe;
      return uses_exe || uses_mem;
   endfunction

   // Drive one cycle, queue its expected response, advance the model, step the clock
   task automatic apply(input stim_t s);
      exp_t e;
      bit fa, busy, fl, st;
      rst              = s.rst;
      bus.id_valid     = s.id_valid;
      bus.id_src1      = s.s1;
      bus.id_src2      = s.s2;
      bus.id_two_src   = s.two;
      bus.exe_wb_en    = s.ewb;
      bus.exe_mem_r_en = s.emr;
      bus.exe_dest     = s.ed;
      bus.mem_wb_en    = s.mwb;
      bus.mem_dest     = s.md;
      bus.fwd_en       = s.fwd;
      bus.branch_taken = s.br;
      bus.mem_req      = s.req;
      bus.mem_ready    = s.rdy;

      fa   = waiting ? !s.rdy : (s.req && !s.rdy);
      busy = waiting && !s.rdy;
      fl   = !fa && s.br;
      st   = !fa && !s.br && hazard_of(s);
      if (!s.rst) begin
         fa = 0; busy = 0; fl = 0; st = 0;
      end
      e.ctl = {st, st, fl, fa, busy};
      e.tmo = timed_out;
      e.sc  = 16'(stalls);
      e.fc  = 16'(flushes);
      exp_q.push_back(e);

      if (!s.rst) begin
         waiting = 0; waited = 0; timed_out = 0; stalls = 0; flushes = 0;
      end else begin
         if ((fa || st) && stalls < 65535) stalls++;
         if (fl && flushes < 65535) flushes++;
         if (waiting) begin
            if (s.rdy) waiting = 0;
            else begin
               if (waited < 255) waited++;
               if (waited >= 255) timed_out = 1;
            end
         end else if (s.req && !s.rdy) begin
            waiting = 1;
            waited  = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every presented cycle against the oldest queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ctl", 16'({bus.freeze_if, bus.bubble_id, bus.flush, bus.freeze_all, bus.mem_busy}), 16'(e.ctl));
            chk("mem_timeout", 16'(bus.mem_timeout), 16'(e.tmo));
            chk("stall_count", bus.stall_count, e.sc);
            chk("flush_count", bus.flush_count, e.fc);
         end
      end
   end

   initial begin
      stim_t idle;
      stim_t s;
      idle = '{rst: 1, id_valid: 0, s1: 0, s2: 0, two: 0, ewb: 0, emr: 0, ed: 0,
               mwb: 0, md: 0, fwd: 0, br: 0, req: 0, rdy: 1};
      waiting = 0; waited = 0; timed_out = 0; stalls = 0; flushes = 0;

      // Initial reset edge (not scored: registers are unknown before it)
      s = idle; s.rst = 0;
      rst = 0;
      bus.id_valid = 0; bus.id_src1 = 0; bus.id_src2 = 0; bus.id_two_src = 0;
      bus.exe_wb_en = 0; bus.exe_mem_r_en = 0; bus.exe_dest = 0;
      bus.mem_wb_en = 0; bus.mem_dest = 0; bus.fwd_en = 0;
      bus.branch_taken = 0; bus.mem_req = 0; bus.mem_ready = 1;
      @(posedge clk);
      #1;

      // Reset state, with busy-looking inputs held low by reset
      s = idle; s.rst = 0; s.req = 1; s.rdy = 0; s.br = 1;
      apply(s);
      apply(idle);

      // Load-use with forwarding
      s = idle; s.fwd = 1; s.emr = 1; s.ewb = 1; s.ed = 3; s.s1 = 3; s.id_valid = 1;
      apply(s);
      apply(idle);

      // No-forward dependency through src2, then src2 unused
      s = idle; s.mwb = 1; s.md = 5; s.two = 1; s.s2 = 5; s.s1 = 9; s.id_valid = 1;
      apply(s);
      s.two = 0;
      apply(s);
      // Forwarding hides a non-load EXE dependency
      s = idle; s.fwd = 1; s.ewb = 1; s.ed = 7; s.s1 = 7; s.id_valid = 1;
      apply(s);
      s.fwd = 0; apply(s); apply(s);

      // Memory wait: 4 not-ready cycles, then release
      s = idle; s.req = 1; s.rdy = 0;
      repeat (4) apply(s);
      s.rdy = 1; apply(s);
      apply(idle);

      // Branch beats hazard
      s = idle; s.br = 1; s.ewb = 1; s.ed = 2; s.s1 = 2; s.id_valid = 1;
      apply(s);
      // Branch held through a 2-cycle wait: one flush at release
      s = idle; s.br = 1; s.req = 1; s.rdy = 0;
      repeat (2) apply(s);
      s.rdy = 1; apply(s);
      apply(idle);

      // Reset in the middle of a wait with nonzero counters
      s = idle; s.req = 1; s.rdy = 0;
      repeat (3) apply(s);
      s.rst = 0; s.br = 1; apply(s);
      s = idle; s.req = 1; s.rdy = 1; apply(s);
      s.rdy = 0; apply(s);
      s.rdy = 1; apply(s);

      // Timeout: 300 not-ready cycles, then release; flag stays set
      s = idle; s.req = 1; s.rdy = 0;
      repeat (300) apply(s);
      s.rdy = 1; apply(s);
      repeat (3) apply(idle);

      // Random traffic over a small register space to provoke hazards
      for (int i = 0; i < 3000; i++) begin
         s.rst      = ($urandom_range(0, 199) != 0);
         s.id_valid = ($urandom_range(0, 3) != 0);
         s.s1       = 4'($urandom_range(0, 3));
         s.s2       = 4'($urandom_range(0, 3));
         s.two      = 1'($urandom);
         s.ewb      = 1'($urandom);
         s.emr      = 1'($urandom);
         s.ed       = 4'($urandom_range(0, 3));
         s.mwb      = 1'($urandom);
         s.md       = 4'($urandom_range(0, 3));
         s.fwd      = 1'($urandom);
         s.br       = ($urandom_range(0, 5) == 0);
         s.req      = ($urandom_range(0, 3) == 0);
         s.rdy      = ($urandom_range(0, 2) != 0);
         apply(s);
      end

      repeat (2) @(posedge clk);
      chk("queue_drained", 16'(exp_q.size()), 16'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
